// File: rtl/rr_arb_mux.sv
// rr_arb_mux -- N-channel streaming arbiter/mux with one output register.
//
// Each input channel offers a beat with a valid/ready handshake. An arbiter
// picks one requesting channel per cycle whenever the output register can
// take a beat. Its search starts at a rotating pointer, which gives
// round-robin order. The winning payload and its channel index are
// registered and presented downstream with their own valid/ready handshake.
//
// Configuration macro:
//   ARB_FIXED_PRIO_EN  when defined, the arbiter always searches from
//                      channel 0 (fixed priority) and no pointer register
//                      exists. Ports and all other behaviour are unchanged.
//
// Ports:
//   clk        in   clock, all state updates on the rising edge
//   rst        in   synchronous active-high reset
//   in_valid   in   [NR_CH]           per-channel request
//   in_ready   out  [NR_CH]           one-hot accept (or all zero)
//   in_data    in   [NR_CH*DATA_LEN]  channel i at [DATA_LEN*i +: DATA_LEN]
//   out_valid  out  output register holds a beat
//   out_ready  in   downstream accepts the beat
//   out_data   out  [DATA_LEN]        registered payload
//   out_sel    out  [SEL_LEN]         channel index that supplied out_data
module rr_arb_mux #(
  parameter int NR_CH    = 4,
  parameter int DATA_LEN = 32,
  localparam int SEL_LEN = (NR_CH > 1) ? $clog2(NR_CH) : 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NR_CH-1:0]          in_valid,
  output logic [NR_CH-1:0]          in_ready,
  input  logic [NR_CH*DATA_LEN-1:0] in_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [DATA_LEN-1:0]       out_data,
  output logic [SEL_LEN-1:0]        out_sel
);

  logic [DATA_LEN-1:0] ch_data [NR_CH];
  logic                out_valid_reg;
  logic [DATA_LEN-1:0] out_data_reg;
  logic [SEL_LEN-1:0]  out_sel_reg;

  logic                can_load;
  logic [NR_CH-1:0]    grant;
  logic                grant_any;
  logic [SEL_LEN-1:0]  grant_idx;
  logic [SEL_LEN-1:0]  cand_idx;
  int                  start_idx;
  int                  cand;

  // Unpack the flat input bus into one word per channel.
  for (genvar gi = 0; gi < NR_CH; gi++) begin : g_unpack
    assign ch_data[gi] = in_data[DATA_LEN*gi +: DATA_LEN];
  end

`ifdef ARB_FIXED_PRIO_EN
  // Fixed priority: the search always begins at channel 0.
  always_comb begin
    start_idx = 0;
  end
`else
  logic [SEL_LEN-1:0] ptr_reg;
  logic [SEL_LEN-1:0] ptr_next;

  always_comb begin
    start_idx = int'(ptr_reg);
  end

  // The channel after the winner searches first next time, wrapping to 0.
  always_comb begin
    ptr_next = ptr_reg;
    if (grant_any) begin
      if (grant_idx == SEL_LEN'(NR_CH - 1)) begin
        ptr_next = '0;
      end else begin
        ptr_next = grant_idx + SEL_LEN'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_reg <= '0;
    end else begin
      ptr_reg <= ptr_next;
    end
  end
`endif

  // The output slot can take a new beat when it is empty or is being drained
  // this cycle, so a beat can leave and another arrive on the same edge.
  assign can_load = ~out_valid_reg | out_ready;

  // Search start_idx, start_idx+1, ... with wrap. The first requester wins.
  always_comb begin
    grant     = '0;
    grant_any = 1'b0;
    grant_idx = '0;
    cand      = 0;
    cand_idx  = '0;
    for (int k = 0; k < NR_CH; k++) begin
      cand = start_idx + k;
      if (cand >= NR_CH) begin
        cand = cand - NR_CH;
      end
      cand_idx = SEL_LEN'(cand);
      if (!grant_any && in_valid[cand_idx]) begin
        grant_any       = 1'b1;
        grant_idx       = cand_idx;
        grant[cand_idx] = 1'b1;
      end
    end
    // No grant while in reset or while the output slot is stalled.
    if (rst || !can_load) begin
      grant     = '0;
      grant_any = 1'b0;
      grant_idx = '0;
    end
  end

  assign in_ready = grant;

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_reg <= 1'b0;
      out_data_reg  <= '0;
      out_sel_reg   <= '0;
    end else if (grant_any) begin
      out_valid_reg <= 1'b1;
      out_data_reg  <= ch_data[grant_idx];
      out_sel_reg   <= grant_idx;
    end else if (out_ready) begin
      // The beat drained with no refill. Data and sel keep their last values.
      out_valid_reg <= 1'b0;
    end
  end

  assign out_valid = out_valid_reg;
  assign out_data  = out_data_reg;
  assign out_sel   = out_sel_reg;

endmodule

// File: tb/tb_rr_arb_mux.sv
// tb_rr_arb_mux -- self-checking bench for rr_arb_mux.
// A behavioural model of the output slot and the round-robin pointer predicts
// in_ready before each edge and out_valid/out_data/out_sel after it. Directed
// phases cover reset, rotation, stall, wrap-around and mid-beat reset. A
// randomized phase follows.
module tb_rr_arb_mux;

  localparam int NR_CH    = 4;
  localparam int DATA_LEN = 32;
  localparam int SEL_LEN  = 2;
  localparam int BUS      = NR_CH * DATA_LEN;

  logic               clk;
  logic               rst;
  logic [NR_CH-1:0]   in_valid;
  logic [NR_CH-1:0]   in_ready;
  logic [BUS-1:0]     in_data;
  logic               out_valid;
  logic               out_ready;
  logic [DATA_LEN-1:0] out_data;
  logic [SEL_LEN-1:0] out_sel;

  int errors = 0;
  int checks = 0;

  // Model state
  bit                  m_valid;
  logic [DATA_LEN-1:0] m_data;
  int                  m_sel;
  int                  m_ptr;
  int                  last_grant;

  rr_arb_mux #(.NR_CH(NR_CH), .DATA_LEN(DATA_LEN)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_sel   (out_sel)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Which channel should win this cycle, or -1 for none.
  function automatic int model_pick();
    int start;
    int c;
    if (rst || (m_valid && !out_ready)) return -1;
`ifdef ARB_FIXED_PRIO_EN
    start = 0;
`else
    start = m_ptr;
`endif
    for (int k = 0; k < NR_CH; k++) begin
      c = (start + k) % NR_CH;
      if (|(in_valid & (NR_CH'(1) << c))) return c;
    end
    return -1;
  endfunction

  task automatic set_data(input int ch, input logic [DATA_LEN-1:0] val);
    logic [BUS-1:0] mask;
    mask    = BUS'({DATA_LEN{1'b1}}) << (ch * DATA_LEN);
    in_data = (in_data & ~mask) | (BUS'(val) << (ch * DATA_LEN));
  endtask

  // One clock: check in_ready before the edge, advance the model, then check outputs.
  task automatic do_cycle();
    int g;
    logic [NR_CH-1:0] er;
    @(negedge clk);
    g  = model_pick();
    er = (g < 0) ? '0 : (NR_CH'(1) << g);
    check("in_ready", 64'(in_ready), 64'(er));
    last_grant = g;
    @(posedge clk);
    if (rst) begin
      m_valid = 1'b0;
      m_data  = '0;
      m_sel   = 0;
      m_ptr   = 0;
    end else if (g >= 0) begin
      m_valid = 1'b1;
      m_data  = DATA_LEN'(in_data >> (g * DATA_LEN));
      m_sel   = g;
      m_ptr   = (g + 1) % NR_CH;
    end else if (out_ready) begin
      m_valid = 1'b0;
    end
    #1;
    check("out_valid", 64'(out_valid), 64'(m_valid));
    check("out_data", 64'(out_data), 64'(m_data));
    check("out_sel", 64'(out_sel), 64'(m_sel));
  endtask

  initial begin
    rst = 1'b1; in_valid = '0; out_ready = 1'b1; in_data = '0;
    m_valid = 1'b0; m_data = '0; m_sel = 0; m_ptr = 0; last_grant = -1;

    // Reset, then idle with nothing requested
    repeat (2) do_cycle();
    rst = 1'b0;
    repeat (3) do_cycle();
    check("idle_out_valid", 64'(out_valid), 64'd0);

    // All channels requesting: rotation ch0,1,2,3,0,...
    for (int i = 0; i < NR_CH; i++) set_data(i, DATA_LEN'(32'hA0 + i));
    in_valid = 4'b1111;
    for (int i = 0; i < 8; i++) begin
      do_cycle();
`ifdef ARB_FIXED_PRIO_EN
      check("rot_sel", 64'(out_sel), 64'd0);
`else
      check("rot_sel", 64'(out_sel), 64'(i % NR_CH));
      check("rot_data", 64'(out_data), 64'(32'hA0 + (i % NR_CH)));
`endif
    end

    // Drain, then a lone ch2 beat that stalls for 3 cycles
    in_valid = '0; do_cycle();
    set_data(2, 32'h55);
    in_valid = 4'b0100; out_ready = 1'b0;
    do_cycle();
    check("stall_load_grant", 64'(last_grant), 64'd2);
    for (int i = 0; i < 3; i++) begin
      do_cycle();
      check("stall_valid", 64'(out_valid), 64'd1);
      check("stall_data", 64'(out_data), 64'(32'h55));
      check("stall_no_grant", 64'(last_grant), 64'hFFFF_FFFF_FFFF_FFFF);
    end
    out_ready = 1'b1;
    do_cycle();
    check("stall_release_grant", 64'(last_grant), 64'd2);

    // Wrap-around from ptr=3
    in_valid = 4'b0100; do_cycle();
    in_valid = 4'b1001; do_cycle();
`ifdef ARB_FIXED_PRIO_EN
    check("wrap_first", 64'(last_grant), 64'd0);
`else
    check("wrap_first", 64'(last_grant), 64'd3);
`endif
    do_cycle();
    check("wrap_second", 64'(last_grant), 64'd0);

    // Reset while a beat is stalled
    out_ready = 1'b0; in_valid = 4'b0010; do_cycle();
    in_valid = 4'b1111;
    rst = 1'b1; do_cycle();
    check("rst_drop_valid", 64'(out_valid), 64'd0);
    rst = 1'b0; out_ready = 1'b1; do_cycle();
    check("rst_ptr_grant", 64'(last_grant), 64'd0);

    // Randomized traffic
    for (int n = 0; n < 400; n++) begin
      rst       = ($urandom_range(0, 39) == 0);
      in_valid  = NR_CH'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < NR_CH; i++) set_data(i, DATA_LEN'($urandom));
      do_cycle();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
